// File: rtl/cix32_defines.sv
// -----------------------------------------------------------------------------
// cix32_defines
// Shared CIX-32 definitions: CPU mode, segment register encoding, segment
// load fault codes, the hidden descriptor cache entry and its reset values.
// -----------------------------------------------------------------------------
package cix32_defines;

  typedef enum logic {
    MODE_REAL      = 1'b0,
    MODE_PROTECTED = 1'b1
  } cpu_mode_t;

  localparam int SEG_ES = 0;
  localparam int SEG_CS = 1;
  localparam int SEG_SS = 2;
  localparam int SEG_DS = 3;
  localparam int SEG_FS = 4;
  localparam int SEG_GS = 5;

  typedef enum logic [1:0] {
    FLT_NONE = 2'd0,
    FLT_GP   = 2'd1,
    FLT_NP   = 2'd2,
    FLT_SS   = 2'd3
  } seg_fault_e;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] limit;
    logic [7:0]  attrs;
    logic        valid;
  } seg_desc_t;

  localparam logic [15:0] CS_RESET_SEL    = 16'hF000;
  localparam logic [31:0] CS_RESET_BASE   = 32'h000F_0000;
  localparam logic [31:0] SEG_RESET_LIMIT = 32'h0000_FFFF;
  localparam logic [7:0]  ATTR_DATA_DEF   = 8'h93;
  localparam logic [7:0]  ATTR_CODE_DEF   = 8'h9B;

endpackage

// File: rtl/cix32_desc_decode.sv
// -----------------------------------------------------------------------------
// cix32_desc_decode
// Combinational decode of an 8-byte GDT/LDT descriptor into a cache entry.
//   i_lo   : descriptor dword at offset 0
//   i_hi   : descriptor dword at offset 4
//   o_desc : base, expanded limit, access byte, valid = present bit
// -----------------------------------------------------------------------------
module cix32_desc_decode
  import cix32_defines::*;
(
  input  logic [31:0] i_lo,
  input  logic [31:0] i_hi,
  output seg_desc_t   o_desc
);

  logic [19:0] w_raw_limit;
  logic        w_unused_bits;

  assign w_raw_limit = {i_hi[19:16], i_lo[15:0]};

  always_comb begin
    o_desc.base  = {i_hi[31:24], i_hi[7:0], i_lo[31:16]};
    // G bit scales the limit to 4 KiB pages, low 12 bits all ones.
    o_desc.limit = i_hi[23] ? {w_raw_limit, 12'hFFF} : {12'b0, w_raw_limit};
    o_desc.attrs = i_hi[15:8];
    o_desc.valid = i_hi[15];
  end

  // D/B, L and AVL are not used by the segment cache.
  assign w_unused_bits = ^i_hi[22:20];

endmodule

// File: rtl/cix32_segment_unit.sv
// -----------------------------------------------------------------------------
// cix32_segment_unit
// Segment selectors plus hidden descriptor cache, GDT descriptor loader and
// a registered, limit-checked linear address translation port.
//   i_clk, i_rst              : clock, synchronous active-high reset
//   i_cpu_mode                : 0 real, 1 protected (sampled at load accept)
//   i_gdtr_base/limit         : GDT location
//   i_wr_* / o_wr_ready       : selector load handshake
//   o_wr_done/o_wr_fault      : one-cycle load result pulses
//   o_fault_code              : reason of the last load, held until next load
//   o_mem_* / i_mem_*         : descriptor dword reads
//   i_rd_idx / o_rd_sel       : combinational selector read
//   i_xl_* / o_xl_*           : translation request / result (1 cycle)
// -----------------------------------------------------------------------------
module cix32_segment_unit
  import cix32_defines::*;
#(
  parameter int NUM_SEGS = 6,
  parameter int IDX_W    = $clog2(NUM_SEGS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cpu_mode,
  input  logic [31:0]      i_gdtr_base,
  input  logic [15:0]      i_gdtr_limit,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [15:0]      i_wr_sel,
  output logic             o_wr_done,
  output logic             o_wr_fault,
  output logic [1:0]       o_fault_code,
  output logic             o_mem_req,
  output logic [31:0]      o_mem_addr,
  input  logic             i_mem_ack,
  input  logic [31:0]      i_mem_rdata,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [15:0]      o_rd_sel,
  input  logic             i_xl_valid,
  input  logic [IDX_W-1:0] i_xl_idx,
  input  logic [31:0]      i_xl_off,
  input  logic [1:0]       i_xl_len,
  output logic             o_xl_out_valid,
  output logic [31:0]      o_xl_lin,
  output logic             o_xl_fault
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH_LO = 2'd1,
    ST_FETCH_HI = 2'd2,
    ST_COMMIT   = 2'd3
  } seg_state_e;

  seg_state_e       r_state, w_state_nxt;
  logic [15:0]      r_sel [NUM_SEGS];
  seg_desc_t        r_desc [NUM_SEGS];
  logic [IDX_W-1:0] r_idx;
  logic [15:0]      r_sel_lat;
  logic [31:0]      r_addr, r_lo, r_hi;

  logic      w_accept, w_null, w_ti, w_lim_flt, w_cs_ss, w_wr_ok, w_commit_ok;
  seg_desc_t w_dec, w_xl_desc;
  logic      w_unused_attrs;

  cix32_desc_decode u_desc_decode (
    .i_lo   (r_lo),
    .i_hi   (r_hi),
    .o_desc (w_dec)
  );

  assign w_null      = (i_wr_sel[15:2] == 14'd0);
  assign w_ti        = i_wr_sel[2];
  // Last byte of the 8-byte descriptor must lie within the GDT.
  assign w_lim_flt   = ({i_wr_sel[15:3], 3'b111} > i_gdtr_limit);
  assign w_cs_ss     = (i_wr_idx == IDX_W'(SEG_SS)) || (i_wr_idx == IDX_W'(SEG_CS));
  assign w_wr_ok     = (32'(i_wr_idx) < NUM_SEGS);
  assign w_commit_ok = (32'(r_idx) < NUM_SEGS);

  assign o_wr_ready = (r_state == ST_IDLE);
  assign o_mem_req  = (r_state == ST_FETCH_LO) || (r_state == ST_FETCH_HI);
  assign o_mem_addr = r_addr;
  assign o_rd_sel   = (32'(i_rd_idx) < NUM_SEGS) ? r_sel[i_rd_idx] : 16'h0000;
  assign w_xl_desc  = (32'(i_xl_idx) < NUM_SEGS) ? r_desc[i_xl_idx] : '0;
  assign w_unused_attrs = ^w_xl_desc.attrs;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_wr_valid) begin
          w_accept = 1'b1;
          if (i_cpu_mode == MODE_PROTECTED && !w_null && !w_ti && !w_lim_flt)
            w_state_nxt = ST_FETCH_LO;
        end
      end
      ST_FETCH_LO: if (i_mem_ack) w_state_nxt = ST_FETCH_HI;
      ST_FETCH_HI: if (i_mem_ack) w_state_nxt = ST_COMMIT;
      ST_COMMIT:   w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_SEGS; i++) begin
        r_sel[i]  <= (i == SEG_CS) ? CS_RESET_SEL : 16'h0000;
        r_desc[i] <= (i == SEG_CS)
                     ? seg_desc_t'{CS_RESET_BASE, SEG_RESET_LIMIT, ATTR_CODE_DEF, 1'b1}
                     : seg_desc_t'{32'h0, SEG_RESET_LIMIT, ATTR_DATA_DEF, 1'b1};
      end
      r_idx          <= '0;
      r_sel_lat      <= 16'h0000;
      r_addr         <= 32'h0;
      r_lo           <= 32'h0;
      r_hi           <= 32'h0;
      o_wr_done      <= 1'b0;
      o_wr_fault     <= 1'b0;
      o_fault_code   <= FLT_NONE;
      o_xl_out_valid <= 1'b0;
      o_xl_lin       <= 32'h0;
      o_xl_fault     <= 1'b0;
    end else begin
      o_wr_done  <= 1'b0;
      o_wr_fault <= 1'b0;

      if (w_accept) begin
        r_idx        <= i_wr_idx;
        r_sel_lat    <= i_wr_sel;
        r_addr       <= i_gdtr_base + {16'h0, i_wr_sel[15:3], 3'b000};
        o_fault_code <= FLT_NONE;
        if (i_cpu_mode == MODE_REAL) begin
          // Limit and attributes persist so unreal-mode limits survive.
          if (w_wr_ok) begin
            r_sel[i_wr_idx]       <= i_wr_sel;
            r_desc[i_wr_idx].base <= {12'h000, i_wr_sel, 4'h0};
            r_desc[i_wr_idx].valid <= 1'b1;
          end
          o_wr_done <= 1'b1;
        end else if (w_null) begin
          if (w_cs_ss) begin
            o_wr_fault   <= 1'b1;
            o_fault_code <= FLT_GP;
          end else begin
            if (w_wr_ok) begin
              r_sel[i_wr_idx]        <= i_wr_sel;
              r_desc[i_wr_idx].valid <= 1'b0;
            end
            o_wr_done <= 1'b1;
          end
        end else if (w_ti || w_lim_flt) begin
          o_wr_fault   <= 1'b1;
          o_fault_code <= FLT_GP;
        end
      end

      if (r_state == ST_FETCH_LO && i_mem_ack) begin
        r_lo   <= i_mem_rdata;
        r_addr <= r_addr + 32'd4;
      end
      if (r_state == ST_FETCH_HI && i_mem_ack) r_hi <= i_mem_rdata;

      if (r_state == ST_COMMIT) begin
        if (!w_dec.attrs[7]) begin
          o_wr_fault   <= 1'b1;
          o_fault_code <= (r_idx == IDX_W'(SEG_SS)) ? FLT_SS : FLT_NP;
        end else begin
          if (w_commit_ok) begin
            r_sel[r_idx]  <= r_sel_lat;
            r_desc[r_idx] <= w_dec;
          end
          o_wr_done <= 1'b1;
        end
      end

      o_xl_out_valid <= i_xl_valid;
      if (i_xl_valid) begin
        o_xl_lin   <= w_xl_desc.base + i_xl_off;
        // 33-bit sum so an offset that wraps past 4 GiB still faults.
        o_xl_fault <= !w_xl_desc.valid ||
                      (({1'b0, i_xl_off} + {31'b0, i_xl_len}) > {1'b0, w_xl_desc.limit});
      end
    end
  end

endmodule

// File: tb/tb_cix32_segment_unit.sv
module tb_cix32_segment_unit;
  import cix32_defines::*;

  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cpu_mode = MODE_REAL;
  logic [31:0]      gdtr_base = 32'h0;
  logic [15:0]      gdtr_limit = 16'h0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [IDX_W-1:0] wr_idx = '0;
  logic [15:0]      wr_sel = 16'h0;
  logic             wr_done, wr_fault;
  logic [1:0]       fault_code;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic             mem_ack = 1'b0;
  logic [31:0]      mem_rdata = 32'h0;
  logic [IDX_W-1:0] rd_idx = '0;
  logic [15:0]      rd_sel;
  logic             xl_valid = 1'b0;
  logic [IDX_W-1:0] xl_idx = '0;
  logic [31:0]      xl_off = 32'h0;
  logic [1:0]       xl_len = 2'd0;
  logic             xl_out_valid;
  logic [31:0]      xl_lin;
  logic             xl_fault;

  cix32_segment_unit #(.NUM_SEGS(6), .IDX_W(IDX_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_cpu_mode(cpu_mode),
    .i_gdtr_base(gdtr_base), .i_gdtr_limit(gdtr_limit),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_idx(wr_idx), .i_wr_sel(wr_sel),
    .o_wr_done(wr_done), .o_wr_fault(wr_fault), .o_fault_code(fault_code),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .i_rd_idx(rd_idx), .o_rd_sel(rd_sel),
    .i_xl_valid(xl_valid), .i_xl_idx(xl_idx), .i_xl_off(xl_off), .i_xl_len(xl_len),
    .o_xl_out_valid(xl_out_valid), .o_xl_lin(xl_lin), .o_xl_fault(xl_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic       fault;
    logic [1:0] code;
    int         at_cyc;
  } ld_exp_t;

  typedef struct {
    logic [31:0] lin;
    logic        fault;
  } xl_exp_t;

  ld_exp_t ld_q[$];
  xl_exp_t xl_q[$];

  always @(negedge clk) begin
    ld_exp_t e;
    xl_exp_t x;
    if (wr_done || wr_fault) begin
      if (ld_q.size() == 0) check("ld_unexpected", {62'b0, wr_done, wr_fault}, 64'd0);
      else begin
        e = ld_q.pop_front();
        check("ld_done", wr_done, !e.fault);
        check("ld_fault", wr_fault, e.fault);
        check("ld_code", fault_code, e.code);
        check("ld_cycle", cyc, e.at_cyc);
      end
    end
    if (xl_out_valid) begin
      if (xl_q.size() == 0) check("xl_unexpected", xl_out_valid, 1'b0);
      else begin
        x = xl_q.pop_front();
        check("xl_lin", xl_lin, x.lin);
        check("xl_fault", xl_fault, x.fault);
      end
    end
  end

  // lat: 1 for real/pre-fetch results, 4 for a descriptor fetch; waits per dword.
  task automatic load(input int idx, input logic [15:0] sel, input int lat, input int waits,
                      input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] a0,
                      input logic flt, input logic [1:0] code);
    int k;
    @(posedge clk); #1;
    check("wr_ready", wr_ready, 1'b1);
    wr_valid = 1'b1; wr_idx = IDX_W'(idx); wr_sel = sel;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    ld_q.push_back('{flt, code, cyc + lat - 1 + 2 * waits});
    if (lat == 1) check("no_mem_req", mem_req, 1'b0);
    else begin
      for (int d = 0; d < 2; d++) begin
        for (int w = 0; w < waits; w++) begin
          check("mem_addr_wait", mem_addr, a0 + 32'(4 * d));
          @(posedge clk); #1;
        end
        check("mem_req", mem_req, 1'b1);
        check("mem_addr", mem_addr, a0 + 32'(4 * d));
        mem_ack = 1'b1; mem_rdata = (d == 0) ? lo : hi;
        @(posedge clk); #1;
        mem_ack = 1'b0;
      end
    end
    k = 0;
    while (ld_q.size() != 0 && k < 40) begin @(posedge clk); #1; k++; end
    if (ld_q.size() != 0) begin
      check("ld_timeout", 64'(ld_q.size()), 64'd0);
      ld_q.delete();
    end
    check("fault_code_held", fault_code, code);
  endtask

  task automatic xlate(input int idx, input logic [31:0] off, input logic [1:0] len,
                       input logic [31:0] lin, input logic flt);
    @(posedge clk); #1;
    xl_valid = 1'b1; xl_idx = IDX_W'(idx); xl_off = off; xl_len = len;
    xl_q.push_back('{lin, flt});
    @(posedge clk); #1;
    xl_valid = 1'b0;
    @(posedge clk); #1;
    check("xl_drain", 64'(xl_q.size()), 64'd0);
  endtask

  task automatic sel_is(input int idx, input logic [15:0] exp);
    rd_idx = IDX_W'(idx);
    #1;
    check("rd_sel", rd_sel, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_wr_done", wr_done, 1'b0);
    check("rst_wr_fault", wr_fault, 1'b0);
    check("rst_fault_code", fault_code, FLT_NONE);
    check("rst_xl_out_valid", xl_out_valid, 1'b0);
    check("rst_xl_lin", xl_lin, 32'h0);
    check("rst_xl_fault", xl_fault, 1'b0);
    sel_is(SEG_CS, 16'hF000);
    sel_is(SEG_DS, 16'h0000);

    xlate(SEG_CS, 32'h0000_FFF0, 2'd0, 32'h000F_FFF0, 1'b0);
    xlate(SEG_DS, 32'h0001_0000, 2'd0, 32'h0001_0000, 1'b1);
    xlate(SEG_DS, 32'h0000_FFFE, 2'd1, 32'h0000_FFFE, 1'b0);
    xlate(SEG_DS, 32'h0000_FFFE, 2'd3, 32'h0000_FFFE, 1'b1);

    // Real mode load
    load(SEG_DS, 16'h1234, 1, 0, 32'h0, 32'h0, 32'h0, 1'b0, FLT_NONE);
    sel_is(SEG_DS, 16'h1234);
    xlate(SEG_DS, 32'h0000_0010, 2'd0, 32'h0001_2350, 1'b0);

    // Protected mode, flat 4 GiB data descriptor
    cpu_mode = MODE_PROTECTED; gdtr_base = 32'h0000_1000; gdtr_limit = 16'h00FF;
    load(SEG_DS, 16'h0010, 4, 0, 32'h0000_FFFF, 32'h00CF_9200, 32'h0000_1010, 1'b0, FLT_NONE);
    sel_is(SEG_DS, 16'h0010);
    xlate(SEG_DS, 32'hFFFF_FFF0, 2'd3, 32'hFFFF_FFF0, 1'b0);
    xlate(SEG_DS, 32'hFFFF_FFFE, 2'd3, 32'hFFFF_FFFE, 1'b1);

    // Byte-granular descriptor with wait states: base 00001234, limit 0FFF
    load(SEG_ES, 16'h0008, 4, 2, 32'h1234_0FFF, 32'h0000_9300, 32'h0000_1008, 1'b0, FLT_NONE);
    xlate(SEG_ES, 32'h0000_0FFC, 2'd3, 32'h0000_2230, 1'b0);
    xlate(SEG_ES, 32'h0000_0FFD, 2'd3, 32'h0000_2231, 1'b1);

    // Pre-fetch faults
    load(SEG_SS, 16'h0000, 1, 0, 32'h0, 32'h0, 32'h0, 1'b1, FLT_GP);
    gdtr_limit = 16'h0017;
    load(SEG_ES, 16'h0018, 1, 0, 32'h0, 32'h0, 32'h0, 1'b1, FLT_GP);
    gdtr_limit = 16'h00FF;
    load(SEG_DS, 16'h0014, 1, 0, 32'h0, 32'h0, 32'h0, 1'b1, FLT_GP);
    sel_is(SEG_ES, 16'h0008);
    xlate(SEG_ES, 32'h0, 2'd0, 32'h0000_1234, 1'b0);

    // Not-present descriptors
    load(SEG_SS, 16'h0020, 4, 0, 32'h5678_FFFF, 32'h1240_1234, 32'h0000_1020, 1'b1, FLT_SS);
    sel_is(SEG_SS, 16'h0000);
    xlate(SEG_SS, 32'h0000_0100, 2'd0, 32'h0000_0100, 1'b0);
    load(SEG_FS, 16'h0028, 4, 1, 32'h5678_FFFF, 32'h1240_1234, 32'h0000_1028, 1'b1, FLT_NP);

    // Null selector into a data segment: committed, entry unusable
    load(SEG_DS, 16'h0003, 1, 0, 32'h0, 32'h0, 32'h0, 1'b0, FLT_NONE);
    sel_is(SEG_DS, 16'h0003);
    xlate(SEG_DS, 32'h0, 2'd0, 32'h0, 1'b1);

    // Mode switch leaves the cache alone; back-to-back translations
    cpu_mode = MODE_REAL;
    @(posedge clk); #1;
    xl_valid = 1'b1; xl_idx = IDX_W'(SEG_CS); xl_off = 32'h0; xl_len = 2'd0;
    xl_q.push_back('{32'h000F_0000, 1'b0});
    @(posedge clk); #1;
    xl_idx = IDX_W'(SEG_ES); xl_off = 32'h10;
    xl_q.push_back('{32'h0000_1244, 1'b0});
    @(posedge clk); #1;
    xl_idx = IDX_W'(SEG_SS); xl_off = 32'hFFFF;
    xl_q.push_back('{32'h0000_FFFF, 1'b0});
    @(posedge clk); #1;
    xl_valid = 1'b0;
    @(posedge clk); #1;
    check("xl_pipe_drain", 64'(xl_q.size()), 64'd0);

    // Reset during FETCH_HI with the high dword withheld
    cpu_mode = MODE_PROTECTED;
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_idx = IDX_W'(SEG_DS); wr_sel = 16'h0010;
    @(posedge clk); #1;
    wr_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("hi_mem_req", mem_req, 1'b1);
    check("hi_mem_addr", mem_addr, 32'h0000_1014);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_mem_req", mem_req, 1'b0);
    check("rst_mid_ready", wr_ready, 1'b1);
    sel_is(SEG_CS, 16'hF000);
    mem_ack = 1'b1; mem_rdata = 32'h00CF_9200;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("late_ack_ready", wr_ready, 1'b1);
    check("late_ack_mem_req", mem_req, 1'b0);
    sel_is(SEG_DS, 16'h0000);
    xlate(SEG_DS, 32'h0000_0010, 2'd0, 32'h0000_0010, 1'b0);

    check("ld_q_empty", 64'(ld_q.size()), 64'd0);
    check("xl_q_empty", 64'(xl_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
